// File: rtl/mips_pkg.sv
// Shared types and widths for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, load control/status and instruction-memory write port.
// Latency: n/a (wiring only).
// Backpressure: in_ready qualifies in_valid; mem write port is never stalled.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    import mips_pkg::*;

    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [WORD_W-1:0] checksum;

    // Host / debug side
    modport master (
        output start, word_count, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, checksum
    );

    // Loader side
    modport slave (
        input  start, word_count, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, checksum
    );

endinterface

// File: rtl/word_assembler.sv
// Shifts big-endian bytes into a 32-bit word; flags the 4th byte.
// Latency: word_out valid the cycle after the 4th byte; word_full is same-cycle.
// Backpressure: none; caller gates byte_en.
module word_assembler
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_full
);

    logic [1:0]        idx;
    logic [WORD_W-1:0] shreg;

    // Byte index and shift register; first byte ends up in the top byte lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 2'd0;
            shreg <= '0;
        end else if (clear) begin
            idx   <= 2'd0;
            shreg <= '0;
        end else if (byte_en) begin
            idx   <= idx + 2'd1;
            shreg <= {shreg[WORD_W-BYTE_W-1:0], byte_in};
        end
    end

    assign word_out  = shreg;
    assign word_full = byte_en && !clear && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a big-endian byte stream into instruction memory from address 0, holding the CPU in reset.
// Latency: write one cycle after the 4th byte of a word; done one cycle after the last write.
// Backpressure: in_ready is registered and drops during writes and once all requested words are in.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH  = 19,
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

    ld_state_t         state;
    logic              in_ready_q;
    logic              mem_we_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;
    logic [WORD_W-1:0] checksum_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;

    logic [ADDR_W:0]   req_cnt;
    logic              clear;
    logic              byte_en;
    logic              word_full;
    logic              last_word;
    logic [WORD_W-1:0] word;

    // Requests larger than the memory are clipped so mem_addr stays in range
    assign req_cnt   = (bus.word_count > DEPTH_N) ? DEPTH_N : bus.word_count;
    assign clear     = (state == IDLE) && bus.start;
    assign byte_en   = bus.in_valid && in_ready_q;
    assign last_word = ({1'b0, addr_q} == (cnt_q - 1'b1));

    word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .byte_en   (byte_en),
        .byte_in   (bus.in_data),
        .word_out  (word),
        .word_full (word_full)
    );

    // Load FSM; every handshake/status output is registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            checksum_q <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt_q      <= req_cnt;
                        err_q      <= (bus.word_count > DEPTH_N);
                        checksum_q <= '0;
                        addr_q     <= '0;
                        if (req_cnt == '0) begin
                            state      <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state      <= LOAD;
                            in_ready_q <= 1'b1;
                            cpu_hold_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (word_full) begin
                        state      <= WRITE;
                        in_ready_q <= 1'b0;
                        mem_we_q   <= 1'b1;
                    end
                end
                WRITE: begin
                    checksum_q <= checksum_q ^ word;
                    if (last_word) begin
                        state      <= DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        addr_q     <= addr_q + 1'b1;
                        state      <= LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = word;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.checksum  = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized stimulus against a cycle-level behavioural model of the loader.
// Latency: n/a.
// Backpressure: in_valid driven randomly; acceptance follows the DUT's in_ready.
module tb_imem_loader;

    localparam int DEPTH  = 19;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Model state: what the loader must be doing this cycle per its timing rules
    bit          busy, pend_we, pend_done, hs_now;
    int          m_cnt, m_bytes, m_writes;
    logic [31:0] m_word, m_chk;
    bit          m_err;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] dut_mem   [DEPTH];
    logic [31:0] wd[$];
    int          wa[$];
    int          done_cnt = 0;
    logic [7:0]  src[$];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            dut_mem[i]   = '0;
        end
    end

    // Compare process: outputs are stable at the falling edge
    always @(negedge clk) begin
        bit exp_we, exp_done, exp_hold, exp_ready, was_busy;
        int wc;
        if (!rst_n) begin
            chk("rst_ctl", {bus.in_ready, bus.mem_we, bus.cpu_hold, bus.done, bus.err}, 0);
            chk("rst_addr", bus.mem_addr, 0);
            chk("rst_wdata", bus.mem_wdata, 0);
            chk("rst_checksum", bus.checksum, 0);
            busy = 0; pend_we = 0; pend_done = 0; hs_now = 0;
            m_word = 0; m_chk = 0; m_err = 0; m_bytes = 0; m_writes = 0; m_cnt = 0;
        end else begin
            exp_we    = pend_we;
            exp_done  = pend_done;
            exp_hold  = busy && !exp_done;
            exp_ready = busy && !exp_we && !exp_done;
            was_busy  = busy;
            chk("in_ready", bus.in_ready, exp_ready);
            chk("mem_we", bus.mem_we, exp_we);
            chk("done", bus.done, exp_done);
            chk("cpu_hold", bus.cpu_hold, exp_hold);
            chk("checksum", bus.checksum, m_chk);
            chk("err", bus.err, m_err);
            if (bus.mem_we) begin
                wa.push_back(int'(bus.mem_addr));
                wd.push_back(bus.mem_wdata);
                chk("addr_range", bus.mem_addr < DEPTH, 1);
                if (bus.mem_addr < DEPTH) dut_mem[bus.mem_addr] = bus.mem_wdata;
            end
            if (exp_we) begin
                chk("mem_addr", bus.mem_addr, m_writes);
                chk("mem_wdata", bus.mem_wdata, m_word);
                if (m_writes < DEPTH) model_mem[m_writes] = m_word;
                m_chk = m_chk ^ m_word;
                m_writes++;
            end
            if (bus.done) done_cnt++;
            pend_we = 0;
            pend_done = 0;
            if (exp_done) busy = 0;
            if (exp_we && m_writes == m_cnt) pend_done = 1;
            if (!was_busy && bus.start) begin
                wc = int'(bus.word_count);
                m_cnt = (wc > DEPTH) ? DEPTH : wc;
                m_err = (wc > DEPTH);
                m_chk = 0; m_writes = 0; m_bytes = 0; m_word = 0;
                busy = 1;
                if (m_cnt == 0) pend_done = 1;
            end
            if (exp_ready && bus.in_valid) begin
                m_word = {m_word[23:0], bus.in_data};
                m_bytes++;
                if (m_bytes % 4 == 0) pend_we = 1;
            end
            hs_now = bus.in_valid && bus.in_ready;
        end
    end

    task automatic do_load(input int wc, input int pct, output int acc);
        int idx, d0, cyc;
        wa.delete();
        wd.delete();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.word_count = (ADDR_W+1)'(wc);
        d0 = done_cnt;
        @(posedge clk); #1;
        bus.start = 1'b0;
        idx = 0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            bus.in_valid = (idx < src.size()) && ($urandom_range(99) < pct);
            bus.in_data  = (idx < src.size()) ? src[idx] : 8'h00;
            @(posedge clk); #1;
            if (hs_now) idx++;
            cyc++;
        end
        chk("load_timeout", cyc < 3000, 1);
        // Keep offering bytes after done: none may be taken
        repeat (3) begin
            bus.in_valid = (idx < src.size());
            bus.in_data  = (idx < src.size()) ? src[idx] : 8'h00;
            @(posedge clk); #1;
            if (hs_now) idx++;
        end
        bus.in_valid = 1'b0;
        acc = idx;
    endtask

    function automatic logic [31:0] wd_at(int i);
        return (i < wd.size()) ? wd[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wa_at(int i);
        return (i < wa.size()) ? wa[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int acc, wc, idx;
        bus.start = 1'b0;
        bus.word_count = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;

        // Basic two-word load
        src = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h04};
        do_load(2, 100, acc);
        chk("basic_nwr", wd.size(), 2);
        chk("basic_w0", wd_at(0), 32'h2008_0005);
        chk("basic_w1", wd_at(1), 32'hAC09_0004);
        chk("basic_a1", wa_at(1), 1);
        chk("basic_checksum", bus.checksum, 32'h8C01_0001);
        chk("basic_bytes", acc, 8);
        chk("basic_hold", bus.cpu_hold, 0);

        // Gappy in_valid
        src = '{8'h00, 8'h00, 8'h00, 8'h20};
        do_load(1, 40, acc);
        chk("bp_w0", wd_at(0), 32'h0000_0020);
        chk("bp_bytes", acc, 4);

        // Overflow: clipped to DEPTH words
        src.delete();
        for (int i = 0; i < 100; i++) src.push_back(8'($urandom));
        do_load(25, 70, acc);
        chk("ovf_nwr", wd.size(), 19);
        chk("ovf_a18", wa_at(18), 18);
        chk("ovf_err", bus.err, 1);
        chk("ovf_bytes", acc, 76);

        // Zero-length load
        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(0, 100, acc);
        chk("zero_nwr", wd.size(), 0);
        chk("zero_err", bus.err, 0);
        chk("zero_bytes", acc, 0);

        // Random loads
        repeat (4) begin
            wc = $urandom_range(1, 6);
            src.delete();
            for (int i = 0; i < wc * 4 + 3; i++) src.push_back(8'($urandom));
            do_load(wc, $urandom_range(30, 100), acc);
            chk("rnd_bytes", acc, wc * 4);
            chk("rnd_nwr", wd.size(), wc);
        end

        // Reset two bytes into word 1, then a fresh single-word load
        src = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.word_count = (ADDR_W+1)'(2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        idx = 0;
        for (int c = 0; c < 100 && idx < 6; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = src[idx];
            @(posedge clk); #1;
            if (hs_now) idx++;
        end
        chk("rstmid_bytes", idx, 6);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        src = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(1, 100, acc);
        chk("rstmid_w0", wd_at(0), 32'h1122_3344);
        chk("rstmid_a0", wa_at(0), 0);

        // Memory image seen by the write port vs model
        for (int i = 0; i < DEPTH; i++) chk("mem_image", dut_mem[i], model_mem[i]);
        chk("mem_word0", dut_mem[0], 32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
